// File: rtl/register_file_if.sv
// Bus bundle for the register file: one general write port, one dedicated R0 write port,
// two indexed read ports and the always-visible R0 read.
interface register_file_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic                  registerWrite;
   logic [ADDR_WIDTH-1:0] regWriteLocal;
   logic [DATA_WIDTH-1:0] dataWrite;
   logic                  r0WriteEn;
   logic [DATA_WIDTH-1:0] r0Write;
   logic [ADDR_WIDTH-1:0] registerRead1;
   logic [ADDR_WIDTH-1:0] registerRead2;
   logic [DATA_WIDTH-1:0] dataRead1;
   logic [DATA_WIDTH-1:0] dataRead2;
   logic [DATA_WIDTH-1:0] r0Read;

   modport master (
      output registerWrite, regWriteLocal, dataWrite,
      output r0WriteEn, r0Write,
      output registerRead1, registerRead2,
      input  dataRead1, dataRead2, r0Read
   );

   modport slave (
      input  registerWrite, regWriteLocal, dataWrite,
      input  r0WriteEn, r0Write,
      input  registerRead1, registerRead2,
      output dataRead1, dataRead2, r0Read
   );
endinterface

// File: rtl/register_file.sv
// 16x16 flip-flop register file: two combinational read ports, a general write port and a
// dedicated R0 write port for the multiply/divide unit. Reset is synchronous, active-high.
module register_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
   input logic             clk,
   input logic             reset_n,
   register_file_if.slave  bus
);
   logic [DATA_WIDTH-1:0] regFileReg [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : genRegs
         logic genHit;
         assign genHit = bus.registerWrite && (bus.regWriteLocal == ADDR_WIDTH'(gi));

         if (gi == 0) begin : genR0
            // The dedicated port is the multiply/divide result and must beat writeback.
            always_ff @(posedge clk) begin
               if (reset_n) begin
                  regFileReg[gi] <= '0;
               end else if (bus.r0WriteEn) begin
                  regFileReg[gi] <= bus.r0Write;
               end else if (genHit) begin
                  regFileReg[gi] <= bus.dataWrite;
               end
            end
         end else begin : genGp
            always_ff @(posedge clk) begin
               if (reset_n) begin
                  regFileReg[gi] <= '0;
               end else if (genHit) begin
                  regFileReg[gi] <= bus.dataWrite;
               end
            end
         end
      end
   endgenerate

   // No write bypass: reads see the stored value until the edge that updates it.
   assign bus.dataRead1 = regFileReg[bus.registerRead1];
   assign bus.dataRead2 = regFileReg[bus.registerRead2];
   assign bus.r0Read    = regFileReg[0];
endmodule

// File: tb/tb_register_file.sv
// Randomized and directed scoreboard bench for register_file against an array model.
module tb_register_file;
   logic clk;
   logic reset_n;

   register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) busIf ();

   register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_REGS(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          txn;
      logic [3:0]  addr1;
      logic [3:0]  addr2;
      logic [15:0] exp1;
      logic [15:0] exp2;
      logic [15:0] expR0;
   } expect_t;

   expect_t     sbQ[$];
   logic [15:0] model [16];
   int          vectors = 0;
   int          miscompares = 0;
   int          txnCount = 0;

   // Issue one cycle of stimulus at the falling edge; record what the reads must show
   // before the following rising edge, then advance the model across that edge.
   task automatic issue(input logic rst, input logic we, input logic [3:0] wa,
                        input logic [15:0] wd, input logic r0we, input logic [15:0] r0d,
                        input logic [3:0] ra1, input logic [3:0] ra2, input bit check);
      expect_t e;
      @(negedge clk);
      reset_n             = rst;
      busIf.registerWrite = we;
      busIf.regWriteLocal = wa;
      busIf.dataWrite     = wd;
      busIf.r0WriteEn     = r0we;
      busIf.r0Write       = r0d;
      busIf.registerRead1 = ra1;
      busIf.registerRead2 = ra2;
      if (check) begin
         e.txn   = txnCount;
         e.addr1 = ra1;
         e.addr2 = ra2;
         e.exp1  = model[ra1];
         e.exp2  = model[ra2];
         e.expR0 = model[0];
         sbQ.push_back(e);
      end
      txnCount++;
      if (rst) begin
         for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      end else begin
         if (we)   model[wa] = wd;
         if (r0we) model[0]  = r0d;
      end
   endtask

   initial begin : monitor
      expect_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            vectors += 3;
            if (busIf.dataRead1 !== e.exp1) begin
               miscompares++;
               $display("FAIL dataRead1 txn %0d addr %0d: got %h expected %h",
                        e.txn, e.addr1, busIf.dataRead1, e.exp1);
            end
            if (busIf.dataRead2 !== e.exp2) begin
               miscompares++;
               $display("FAIL dataRead2 txn %0d addr %0d: got %h expected %h",
                        e.txn, e.addr2, busIf.dataRead2, e.exp2);
            end
            if (busIf.r0Read !== e.expR0) begin
               miscompares++;
               $display("FAIL r0Read txn %0d: got %h expected %h", e.txn, busIf.r0Read, e.expR0);
            end
            $display("txn %0d rd1[%0d]=%h rd2[%0d]=%h r0=%h", e.txn, e.addr1, busIf.dataRead1,
                     e.addr2, busIf.dataRead2, busIf.r0Read);
         end
      end
   end

   initial begin : stimulus
      int budget;
      for (int i = 0; i < 16; i++) model[i] = 16'hxxxx;
      reset_n             = 1'b1;
      busIf.registerWrite = 1'b0;
      busIf.regWriteLocal = '0;
      busIf.dataWrite     = '0;
      busIf.r0WriteEn     = 1'b0;
      busIf.r0Write       = '0;
      busIf.registerRead1 = '0;
      busIf.registerRead2 = '0;

      // Reset with writes requested: reset must override them.
      issue(1, 1, 4'd9, 16'h1111, 1, 16'h2222, 4'd0, 4'd0, 0);
      // Reset state on several index pairs.
      issue(0, 0, 4'd0, 16'h0000, 0, 16'h0000, 4'd1, 4'd2, 1);
      issue(0, 0, 4'd0, 16'h0000, 0, 16'h0000, 4'd3, 4'd4, 1);
      issue(0, 0, 4'd0, 16'h0000, 0, 16'h0000, 4'd5, 4'd6, 1);
      issue(0, 0, 4'd0, 16'h0000, 0, 16'h0000, 4'd9, 4'd0, 1);
      // Write R7, read old value before the edge, new value after.
      issue(0, 1, 4'd7, 16'hABCD, 0, 16'h0000, 4'd1, 4'd7, 1);
      issue(0, 0, 4'd7, 16'hABCD, 0, 16'h0000, 4'd7, 4'd8, 1);
      // Dedicated R0 path.
      issue(0, 0, 4'd0, 16'h0000, 1, 16'hAAAA, 4'd7, 4'd0, 1);
      issue(0, 0, 4'd0, 16'h0000, 0, 16'h0000, 4'd7, 4'd0, 1);
      // Conflict on R0, then simultaneous writes to R3 and R0.
      issue(0, 1, 4'd0, 16'h1234, 1, 16'h5678, 4'd0, 4'd3, 1);
      issue(0, 1, 4'd3, 16'h1234, 1, 16'h5678, 4'd0, 4'd3, 1);
      issue(0, 1, 4'd7, 16'hABCD, 1, 16'hAAAA, 4'd3, 4'd0, 1);
      // Reset mid-operation discards a pending write.
      issue(1, 1, 4'd7, 16'hFFFF, 0, 16'h0000, 4'd7, 4'd0, 1);
      issue(0, 0, 4'd7, 16'h0000, 0, 16'h0000, 4'd7, 4'd0, 1);
      // Disabled writes leave contents alone.
      repeat (4) issue(0, 0, 4'd5, 16'hBEEF, 0, 16'hBEEF, 4'd5, 4'd7, 1);
      issue(0, 0, 4'd0, 16'h0000, 0, 16'h0000, 4'd5, 4'd5, 1);

      for (int n = 0; n < 400; n++) begin
         issue(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
               4'($urandom_range(0, 15)), 16'($urandom),
               ($urandom_range(0, 3) == 0), 16'($urandom),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
      end
      issue(0, 0, 4'd0, 16'h0000, 0, 16'h0000, 4'd0, 4'd15, 1);

      budget = 10;
      while (sbQ.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      #3;
      if (sbQ.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, required 0", sbQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the 16-bit CPU datapath: 16 registers × 16 bits.
- Two combinational read ports feed the ALU operands.
- One clocked general write port is driven by writeback.
- A dedicated R0 write port and an always-visible R0 read output serve the multiply/divide unit, which uses R0 as an implicit destination.

Parameters:
- DATA_WIDTH, 16, width of each register and of all data ports
- ADDR_WIDTH, 4, width of register index ports
- NUM_REGS, 16, number of registers (2**ADDR_WIDTH)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset_n  input  1  synchronous reset, active-high (asserted = 1) despite the _n suffix
- registerWrite  input  1  write enable for general write port
- regWriteLocal  input  ADDR_WIDTH  destination index for general write
- dataWrite  input  DATA_WIDTH  data for general write
- r0WriteEn  input  1  write enable for dedicated R0 port
- r0Write  input  DATA_WIDTH  data for dedicated R0 write
- registerRead1  input  ADDR_WIDTH  read port 1 index
- registerRead2  input  ADDR_WIDTH  read port 2 index
- dataRead1  output  DATA_WIDTH  contents of register[registerRead1]
- dataRead2  output  DATA_WIDTH  contents of register[registerRead2]
- r0Read  output  DATA_WIDTH  contents of R0, always

Behaviour:
- Storage: NUM_REGS × DATA_WIDTH flip-flop array, index 0..15; R0 is an ordinary register, not hardwired to zero.
- Reset:
  - On a rising clk edge with reset_n = 1, all registers become 16'h0000.
  - Reset overrides both write ports in that cycle.
  - Outputs reflect zeros combinationally after that edge.
  - Asserting reset mid-operation discards any pending write on that edge.
- Reads:
  - dataRead1/dataRead2/r0Read are purely combinational from current register contents; zero-cycle latency from an address change.
  - Both ports may read the same index simultaneously.
  - X/unknown read addresses may produce X; no requirement.
- General write: on a rising edge with reset_n = 0 and registerWrite = 1, register[regWriteLocal] <= dataWrite. Any index 0..15 is writable, including R0.
- R0 write: on a rising edge with reset_n = 0 and r0WriteEn = 1, R0 <= r0Write.
- Write/write conflict: when both enables are active and regWriteLocal = 0, r0Write wins. If regWriteLocal ≠ 0, both writes occur on the same edge.
- Read-during-write: no bypass.
  - A read of the register being written returns the old value until the rising edge.
  - The new value is visible immediately after that edge.
- With no enable asserted and no reset, all contents hold indefinitely.
- No other side effects; no handshake.

Test Plan:
- Reset then read:
  - Hold reset_n = 1 across an edge, release; read indices 1/2, 3/4, 5/6 → all read data 16'h0000.
  - r0Read = 16'h0000.
- Write and read-back:
  - registerWrite = 1, regWriteLocal = 7, dataWrite = 16'hABCD, registerRead2 = 7.
  - Before the edge, dataRead2 = 0000; after the edge, dataRead2 = ABCD.
  - Then drop registerWrite, set registerRead1 = 7 → ABCD, registerRead2 = 8 → 0000.
- Dedicated R0 path:
  - r0WriteEn = 1, r0Write = 16'hAAAA, edge → r0Read = AAAA.
  - registerRead2 = 0 → AAAA.
- Conflict:
  - Same edge: registerWrite = 1, regWriteLocal = 0, dataWrite = 1234, r0WriteEn = 1, r0Write = 5678 → R0 = 5678.
  - Repeat with regWriteLocal = 3 → R3 = 1234 and R0 = 5678.
- Reset mid-operation:
  - With R7 = ABCD and R0 = AAAA, assert reset_n = 1 together with registerWrite = 1 (index 7, data FFFF).
  - After the edge, R7 = 0000 and R0 = 0000; release reset, reads of 7/0 stay 0000.
- Write disable:
  - registerWrite = 0 with regWriteLocal = 5, dataWrite = BEEF over several edges → R5 unchanged (0000).
